// File: rtl/float_pack.sv
`default_nettype none
// ============================================================================
//  Module   : float_pack (with package float_type)
//  Purpose  : Multi-cycle normalizer / round-to-nearest-even / packer that
//             turns {sign, signed biased exponent, 48-bit mantissa} into an
//             IEEE-754 single and reports its classification.
//  Revision : 1.0  initial release
// ============================================================================

package float_type;
    typedef enum logic [1:0] {
        ZERO      = 2'd0,
        VALID     = 2'd1,
        OVERFLOW  = 2'd2,
        UNDERFLOW = 2'd3
    } type_of_float;
endpackage

module float_pack
    import float_type::*;
#(
    parameter int BIAS = 127
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [9:0]         in_exponent,
    input  logic [47:0]        in_mantissa,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_float,
    output type_of_float       out_form
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_NORM  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // First stored-exponent value that no longer fits (all-ones exponent)
    localparam logic signed [9:0] c_EXP_INF  = 10'(2 * BIAS + 1);
    localparam logic signed [9:0] c_EXP_ZERO = 10'sd0;
    localparam logic signed [9:0] c_EXP_ONE  = 10'sd1;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic                r_sign;
    logic signed [9:0]   r_exp;
    logic [47:0]         r_mant;
    logic [31:0]         r_out_float;
    type_of_float        r_out_form;

    logic                w_accept;
    logic                w_m_zero;
    logic                w_rshift;
    logic                w_lshift;
    logic                w_round_up;
    logic [24:0]         w_sum;
    logic                w_carry;
    logic [22:0]         w_frac;
    logic signed [9:0]   w_exp_rnd;

    assign w_accept = in_valid && in_ready;
    assign w_m_zero = (r_mant == 48'd0);

    // Normalization decision: right shift on overflow bit, left shift only while
    // the hidden bit is clear and the exponent is still positive
    assign w_rshift = !w_m_zero && r_mant[47];
    assign w_lshift = !w_m_zero && !r_mant[47] && !r_mant[46] && (r_exp > c_EXP_ZERO);

    // Round to nearest even on the 24-bit significand m[46:23]
    assign w_round_up = r_mant[22] && ((|r_mant[21:0]) || r_mant[23]);
    assign w_sum      = {1'b0, r_mant[46:23]} + {24'd0, w_round_up};
    assign w_carry    = w_sum[24];
    assign w_frac     = w_carry ? 23'd0 : w_sum[22:0];
    assign w_exp_rnd  = w_carry ? (r_exp + c_EXP_ONE) : r_exp;

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_next_state = S_NORM;
            S_NORM:  if (!w_lshift) w_next_state = S_ROUND;
            S_ROUND: w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (r_state == S_IDLE) && !rst;
        out_valid = (r_state == S_DONE);
    end

    // Datapath: capture operand, normalize one bit per cycle, round and classify
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign      <= 1'b0;
            r_exp       <= 10'sd0;
            r_mant      <= 48'd0;
            r_out_float <= 32'h0;
            r_out_form  <= ZERO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign <= in_sign;
                        r_exp  <= $signed(in_exponent);
                        r_mant <= in_mantissa;
                    end
                end
                S_NORM: begin
                    if (w_rshift) begin
                        // keep the shifted-out bit as a sticky contribution
                        r_mant <= {1'b0, r_mant[47:2], r_mant[1] | r_mant[0]};
                        r_exp  <= r_exp + c_EXP_ONE;
                    end else if (w_lshift) begin
                        r_mant <= {r_mant[46:0], 1'b0};
                        r_exp  <= r_exp - c_EXP_ONE;
                    end
                end
                S_ROUND: begin
                    if (w_m_zero) begin
                        r_out_float <= {r_sign, 31'd0};
                        r_out_form  <= ZERO;
                    end else if (w_exp_rnd >= c_EXP_INF) begin
                        r_out_float <= {r_sign, 8'hFF, 23'd0};
                        r_out_form  <= OVERFLOW;
                    end else if (w_exp_rnd <= c_EXP_ZERO) begin
                        // no denormals: flush to signed zero
                        r_out_float <= {r_sign, 31'd0};
                        r_out_form  <= UNDERFLOW;
                    end else begin
                        r_out_float <= {r_sign, w_exp_rnd[7:0], w_frac};
                        r_out_form  <= VALID;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_float = r_out_float;
    assign out_form  = r_out_form;

endmodule
`default_nettype wire
